// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS controller: Moore FSM sequencing each instruction over 3-5 cycles,
// with memory wait states, optional extended opcodes, illegal flag and retire counter.
module multicycle_control_unit #(
  parameter bit MEM_WAIT = 1'b1,
  parameter bit EXT_OPS  = 1'b1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             IorD,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             ALUSrcA,
  output logic             ZeroExt,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSrc,
  output logic [2:0]       ALUControl,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             PCEn,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
    S_BRANCH = 4'd8,  S_IEXEC  = 4'd9,  S_IMMWB  = 4'd10, S_JUMP  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW   = 6'b100011, OP_SW   = 6'b101011,
                         OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI = 6'b001000,
                         OP_ANDI  = 6'b001100, OP_ORI  = 6'b001101, OP_SLTI = 6'b001010,
                         OP_J     = 6'b000010;

  state_t cur, nxt;
  logic   ready, retire;
  logic   ir_w, reg_w, mem_w, pc_en, ill;

  assign ready = MEM_WAIT ? mem_ready : 1'b1;
  assign state = cur;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur         <= S_FETCH;
      instr_count <= '0;
    end else begin
      cur <= nxt;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    nxt        = cur;
    retire     = 1'b0;
    IorD       = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    ALUSrcA    = 1'b0;
    ZeroExt    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    ALUControl = 3'b010;
    ir_w       = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    pc_en      = 1'b0;
    ill        = 1'b0;
    case (cur)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        ir_w    = ready;
        pc_en   = ready;
        if (ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        if (opcode == OP_LW || opcode == OP_SW)               nxt = S_MEMADR;
        else if (opcode == OP_RTYPE)                          nxt = S_EXEC;
        else if (opcode == OP_BEQ || (EXT_OPS && opcode == OP_BNE)) nxt = S_BRANCH;
        else if (opcode == OP_ADDI || (EXT_OPS && (opcode == OP_ANDI ||
                 opcode == OP_ORI || opcode == OP_SLTI)))     nxt = S_IEXEC;
        else if (opcode == OP_J)                              nxt = S_JUMP;
        else begin
          ill = 1'b1;
          nxt = S_FETCH;
        end
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD = 1'b1;
        if (ready) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        reg_w    = 1'b1;
        retire   = 1'b1;
        nxt      = S_FETCH;
      end
      S_MEMWR: begin
        // MemWrite stays high for the whole dwell; the store retires on the ready cycle
        IorD  = 1'b1;
        mem_w = 1'b1;
        if (ready) begin
          retire = 1'b1;
          nxt    = S_FETCH;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        nxt     = S_ALUWB;
        case (funct)
          6'b100000: ALUControl = 3'b010;
          6'b100010: ALUControl = 3'b100;
          6'b101010: ALUControl = 3'b110;
          6'b011100: ALUControl = 3'b101;
          6'b100100: if (EXT_OPS) ALUControl = 3'b000; else begin ill = 1'b1; nxt = S_FETCH; end
          6'b100101: if (EXT_OPS) ALUControl = 3'b001; else begin ill = 1'b1; nxt = S_FETCH; end
          default: begin
            ill = 1'b1;
            nxt = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        RegDst = 1'b1;
        reg_w  = 1'b1;
        retire = 1'b1;
        nxt    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = 3'b100;
        PCSrc      = 2'b01;
        pc_en      = (EXT_OPS && opcode == OP_BNE) ? ~zero : zero;
        retire     = 1'b1;
        nxt        = S_FETCH;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = S_IMMWB;
        case (opcode)
          OP_ANDI: begin ALUControl = 3'b000; ZeroExt = 1'b1; end
          OP_ORI:  begin ALUControl = 3'b001; ZeroExt = 1'b1; end
          OP_SLTI: ALUControl = 3'b110;
          default: ALUControl = 3'b010;
        endcase
      end
      S_IMMWB: begin
        reg_w  = 1'b1;
        retire = 1'b1;
        nxt    = S_FETCH;
      end
      S_JUMP: begin
        PCSrc  = 2'b10;
        pc_en  = 1'b1;
        retire = 1'b1;
        nxt    = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // Strobes are suppressed while reset is held so an aborted instruction writes nothing
  assign IRWrite  = ir_w  & rst_n;
  assign RegWrite = reg_w & rst_n;
  assign MemWrite = mem_w & rst_n;
  assign PCEn     = pc_en & rst_n;
  assign illegal  = ill   & rst_n;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: u_ext (waits + extended ops, 4-bit count) and u_base (no waits, base ops).
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, zero, mem_ready;
  logic [5:0] opcode, funct;

  logic       a_IorD, a_MemtoReg, a_RegDst, a_ALUSrcA, a_ZeroExt;
  logic [1:0] a_ALUSrcB, a_PCSrc;
  logic [2:0] a_ALUControl;
  logic       a_IRWrite, a_RegWrite, a_MemWrite, a_PCEn, a_illegal;
  logic [3:0] a_instr_count, a_state;

  logic       b_IorD, b_MemtoReg, b_RegDst, b_ALUSrcA, b_ZeroExt;
  logic [1:0] b_ALUSrcB, b_PCSrc;
  logic [2:0] b_ALUControl;
  logic       b_IRWrite, b_RegWrite, b_MemWrite, b_PCEn, b_illegal;
  logic [3:0] b_instr_count, b_state;

  int n_cmp  = 0;
  int n_fail = 0;

  multicycle_control_unit #(.MEM_WAIT(1'b1), .EXT_OPS(1'b1), .CNT_W(4)) u_ext (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .IorD(a_IorD), .MemtoReg(a_MemtoReg), .RegDst(a_RegDst), .ALUSrcA(a_ALUSrcA), .ZeroExt(a_ZeroExt),
    .ALUSrcB(a_ALUSrcB), .PCSrc(a_PCSrc), .ALUControl(a_ALUControl), .IRWrite(a_IRWrite),
    .RegWrite(a_RegWrite), .MemWrite(a_MemWrite), .PCEn(a_PCEn), .illegal(a_illegal),
    .instr_count(a_instr_count), .state(a_state));

  multicycle_control_unit #(.MEM_WAIT(1'b0), .EXT_OPS(1'b0), .CNT_W(4)) u_base (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .IorD(b_IorD), .MemtoReg(b_MemtoReg), .RegDst(b_RegDst), .ALUSrcA(b_ALUSrcA), .ZeroExt(b_ZeroExt),
    .ALUSrcB(b_ALUSrcB), .PCSrc(b_PCSrc), .ALUControl(b_ALUControl), .IRWrite(b_IRWrite),
    .RegWrite(b_RegWrite), .MemWrite(b_MemWrite), .PCEn(b_PCEn), .illegal(b_illegal),
    .instr_count(b_instr_count), .state(b_state));

  // Advance one clock; inputs are changed and outputs sampled half a period from the edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b000010; funct = 6'd0; zero = 1'b0;
    repeat (2) tick();
    n_cmp++; if (a_state !== 4'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", a_state); end
    n_cmp++; if (a_instr_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", a_instr_count); end
    n_cmp++; if ({a_IRWrite, a_PCEn, a_RegWrite, a_MemWrite, a_illegal} !== 5'b0)
      begin n_fail++; $display("FAIL reset_strobes got %b want 00000", {a_IRWrite, a_PCEn, a_RegWrite, a_MemWrite, a_illegal}); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (a_IRWrite !== 1'b1) begin n_fail++; $display("FAIL release_irwrite got %b want 1", a_IRWrite); end
  endtask

  task automatic test_lw();
    logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    opcode = 6'b100011; mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (a_state !== exp_st[i]) begin n_fail++; $display("FAIL lw_state[%0d] got %0d want %0d", i, a_state, exp_st[i]); end
      if (i == 0) begin
        n_cmp++; if ({a_IRWrite, a_PCEn} !== 2'b11) begin n_fail++; $display("FAIL lw_fetch_strobes got %b want 11", {a_IRWrite, a_PCEn}); end
      end
      if (i == 2) begin
        n_cmp++; if ({a_ALUSrcA, a_ALUSrcB} !== 3'b110) begin n_fail++; $display("FAIL lw_memadr_src got %b want 110", {a_ALUSrcA, a_ALUSrcB}); end
      end
      if (i == 3) begin
        n_cmp++; if (a_IorD !== 1'b1) begin n_fail++; $display("FAIL lw_memrd_iord got %b want 1", a_IorD); end
      end
      if (i == 4) begin
        n_cmp++; if ({a_RegWrite, a_MemtoReg} !== 2'b11) begin n_fail++; $display("FAIL lw_memwb got %b want 11", {a_RegWrite, a_MemtoReg}); end
      end
      tick();
    end
    n_cmp++; if (a_state !== 4'd0) begin n_fail++; $display("FAIL lw_return got %0d want 0", a_state); end
    n_cmp++; if (a_instr_count !== 4'd1) begin n_fail++; $display("FAIL lw_count got %0d want 1", a_instr_count); end
  endtask

  task automatic test_rtype();
    logic [5:0] fn  [2] = '{6'b101010, 6'b011100};
    logic [2:0] alu [2] = '{3'b110, 3'b101};
    for (int k = 0; k < 2; k++) begin
      opcode = 6'b000000; funct = fn[k];
      #1;
      tick();
      n_cmp++; if (a_state !== 4'd1) begin n_fail++; $display("FAIL rtype%0d_decode got %0d want 1", k, a_state); end
      tick();
      n_cmp++; if ({a_state, a_ALUControl} !== {4'd6, alu[k]})
        begin n_fail++; $display("FAIL rtype%0d_exec got st=%0d alu=%b want st=6 alu=%b", k, a_state, a_ALUControl, alu[k]); end
      tick();
      n_cmp++; if ({a_state, a_RegDst, a_RegWrite} !== {4'd7, 2'b11})
        begin n_fail++; $display("FAIL rtype%0d_aluwb got st=%0d dst/wr=%b%b want 7 11", k, a_state, a_RegDst, a_RegWrite); end
      tick();
      n_cmp++; if (a_state !== 4'd0) begin n_fail++; $display("FAIL rtype%0d_return got %0d want 0", k, a_state); end
    end
    n_cmp++; if (a_instr_count !== 4'd3) begin n_fail++; $display("FAIL rtype_count got %0d want 3", a_instr_count); end
  endtask

  task automatic test_branch();
    logic [5:0] op [2] = '{6'b000100, 6'b000101};
    logic       pe [2] = '{1'b1, 1'b0};
    zero = 1'b1;
    for (int k = 0; k < 2; k++) begin
      opcode = op[k];
      #1;
      tick(); tick();
      n_cmp++; if ({a_state, a_PCEn, a_PCSrc, a_ALUControl} !== {4'd8, pe[k], 2'b01, 3'b100})
        begin n_fail++; $display("FAIL branch%0d got st=%0d pcen=%b pcsrc=%b alu=%b want st=8 pcen=%b 01 100",
                                 k, a_state, a_PCEn, a_PCSrc, a_ALUControl, pe[k]); end
      tick();
      n_cmp++; if (a_state !== 4'd0) begin n_fail++; $display("FAIL branch%0d_return got %0d want 0", k, a_state); end
    end
    zero = 1'b0;
    n_cmp++; if (a_instr_count !== 4'd5) begin n_fail++; $display("FAIL branch_count got %0d want 5", a_instr_count); end
  endtask

  task automatic test_sw_stall();
    int mw_cycles = 0;
    opcode = 6'b101011; mem_ready = 1'b1;
    #1;
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_ready = 1'b1;
      #1;
      n_cmp++; if ({a_state, a_IorD} !== {4'd5, 1'b1}) begin n_fail++; $display("FAIL sw_hold%0d got st=%0d iord=%b want 5 1", k, a_state, a_IorD); end
      if (a_MemWrite === 1'b1) mw_cycles++;
      tick();
    end
    n_cmp++; if (mw_cycles != 4) begin n_fail++; $display("FAIL sw_memwrite_cycles got %0d want 4", mw_cycles); end
    n_cmp++; if ({a_state, a_instr_count} !== {4'd0, 4'd6})
      begin n_fail++; $display("FAIL sw_return got st=%0d cnt=%0d want 0 6", a_state, a_instr_count); end
    opcode = 6'b000010; mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_ready = 1'b1;
      #1;
      n_cmp++; if ({a_state, a_IRWrite, a_PCEn} !== {4'd0, k == 3, k == 3})
        begin n_fail++; $display("FAIL fetch_stall%0d got st=%0d ir/pc=%b%b want 0 %b%b", k, a_state, a_IRWrite, a_PCEn, k == 3, k == 3); end
      tick();
    end
    tick();
    n_cmp++; if ({a_state, a_PCEn, a_PCSrc} !== {4'd11, 1'b1, 2'b10})
      begin n_fail++; $display("FAIL jump got st=%0d pcen=%b pcsrc=%b want 11 1 10", a_state, a_PCEn, a_PCSrc); end
    tick();
    n_cmp++; if ({a_state, a_instr_count} !== {4'd0, 4'd7})
      begin n_fail++; $display("FAIL jump_return got st=%0d cnt=%0d want 0 7", a_state, a_instr_count); end
  endtask

  task automatic test_ext_off();
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'b001101; funct = 6'd0;
    tick();
    rst_n = 1'b1;
    #1;
    n_cmp++; if ({b_state, b_IRWrite, b_PCEn, b_IorD, b_MemtoReg, b_RegDst, b_ALUSrcA, b_ZeroExt, b_ALUSrcB,
                  b_PCSrc, b_ALUControl, b_RegWrite, b_MemWrite, b_illegal} !== {4'd0, 7'b1100000, 2'b01, 2'b00, 3'b010, 3'b000})
      begin n_fail++; $display("FAIL base_fetch_outputs got st=%0d ir=%b pc=%b srcb=%b alu=%b", b_state, b_IRWrite, b_PCEn, b_ALUSrcB, b_ALUControl); end
    tick();
    n_cmp++; if ({b_state, b_illegal} !== {4'd1, 1'b1}) begin n_fail++; $display("FAIL base_ori_illegal got st=%0d ill=%b want 1 1", b_state, b_illegal); end
    tick();
    n_cmp++; if ({b_state, b_illegal, b_instr_count} !== {4'd0, 1'b0, 4'd0})
      begin n_fail++; $display("FAIL base_ori_after got st=%0d ill=%b cnt=%0d want 0 0 0", b_state, b_illegal, b_instr_count); end
    opcode = 6'b000000; funct = 6'b000000;
    #1;
    tick();
    n_cmp++; if ({b_state, b_illegal} !== {4'd1, 1'b0}) begin n_fail++; $display("FAIL base_r_decode got st=%0d ill=%b want 1 0", b_state, b_illegal); end
    tick();
    n_cmp++; if ({b_state, b_illegal, b_RegWrite} !== {4'd6, 1'b1, 1'b0})
      begin n_fail++; $display("FAIL base_r_exec got st=%0d ill=%b wr=%b want 6 1 0", b_state, b_illegal, b_RegWrite); end
    tick();
    n_cmp++; if ({b_state, b_instr_count} !== {4'd0, 4'd0}) begin n_fail++; $display("FAIL base_r_after got st=%0d cnt=%0d want 0 0", b_state, b_instr_count); end
    n_cmp++; if ({a_state, a_IRWrite} !== {4'd0, 1'b0}) begin n_fail++; $display("FAIL ext_wait_hold got st=%0d ir=%b want 0 0", a_state, a_IRWrite); end
  endtask

  task automatic test_ext_ops();
    logic [5:0] op  [3] = '{6'b001100, 6'b001101, 6'b001010};
    logic [2:0] alu [3] = '{3'b000, 3'b001, 3'b110};
    logic       ze  [3] = '{1'b1, 1'b1, 1'b0};
    logic [5:0] fn  [2] = '{6'b100100, 6'b100101};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      opcode = op[k];
      #1;
      tick(); tick();
      n_cmp++; if ({a_state, a_ALUControl, a_ZeroExt} !== {4'd9, alu[k], ze[k]})
        begin n_fail++; $display("FAIL iexec%0d got st=%0d alu=%b zx=%b want 9 %b %b", k, a_state, a_ALUControl, a_ZeroExt, alu[k], ze[k]); end
      tick();
      n_cmp++; if ({a_state, a_RegWrite} !== {4'd10, 1'b1}) begin n_fail++; $display("FAIL immwb%0d got st=%0d wr=%b want 10 1", k, a_state, a_RegWrite); end
      tick();
    end
    opcode = 6'b000000;
    for (int k = 0; k < 2; k++) begin
      funct = fn[k];
      #1;
      tick(); tick();
      n_cmp++; if ({a_state, a_ALUControl} !== {4'd6, alu[k]})
        begin n_fail++; $display("FAIL ext_rtype%0d got st=%0d alu=%b want 6 %b", k, a_state, a_ALUControl, alu[k]); end
      tick(); tick();
    end
    n_cmp++; if ({a_state, a_instr_count} !== {4'd0, 4'd5})
      begin n_fail++; $display("FAIL ext_count got st=%0d cnt=%0d want 0 5", a_state, a_instr_count); end
  endtask

  task automatic test_reset_mid();
    opcode = 6'b100011; mem_ready = 1'b1;
    #1;
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    n_cmp++; if (a_state !== 4'd3) begin n_fail++; $display("FAIL mid_memrd got %0d want 3", a_state); end
    rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    tick();
    n_cmp++; if ({a_state, a_instr_count, a_RegWrite, a_IRWrite, a_PCEn} !== {4'd0, 4'd0, 3'b000})
      begin n_fail++; $display("FAIL mid_reset got st=%0d cnt=%0d wr/ir/pc=%b%b%b want 0 0 000",
                               a_state, a_instr_count, a_RegWrite, a_IRWrite, a_PCEn); end
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    opcode = 6'b000010; mem_ready = 1'b1;
    #1;
    repeat (45) tick();
    n_cmp++; if ({a_state, a_instr_count} !== {4'd0, 4'd15})
      begin n_fail++; $display("FAIL wrap_preload got st=%0d cnt=%0d want 0 15", a_state, a_instr_count); end
    repeat (3) tick();
    n_cmp++; if ({a_state, a_instr_count} !== {4'd0, 4'd0})
      begin n_fail++; $display("FAIL wrap got st=%0d cnt=%0d want 0 0", a_state, a_instr_count); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_branch();
    test_sw_stall();
    test_ext_off();
    test_ext_ops();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle MIPS controller: a Moore state machine that sequences each instruction over 3–5 cycles and drives the shared-memory/single-ALU datapath.
- Successor to the single-cycle decoder; keeps its ALUControl encoding.
- Adds memory wait states (`mem_ready` handshake), optional extended opcodes (bne/andi/ori/slti, R-type and/or), an illegal-opcode flag and a retired-instruction counter.
- Sits between the instruction register (opcode/funct), the ALU zero flag and the datapath mux/enable controls.

## Interface
- MEM_WAIT, 1: 1 = memory states hold until `mem_ready`; 0 = `mem_ready` ignored, treated as 1.
- EXT_OPS, 1: 1 = bne, andi, ori, slti, R-type and/or decoded; 0 = these are illegal.
- CNT_W, 32: width of retired-instruction counter.
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- opcode  in  6  instr[31:26], valid from DECODE onward.
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- IorD, MemtoReg, RegDst, ALUSrcA, ZeroExt  out  1  datapath mux selects.
- ALUSrcB  out  2  00 regB, 01 constant 4, 10 immediate, 11 signimm<<2.
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- ALUControl  out  3  010 add, 100 sub, 110 slt, 101 funct 011100, 000 and, 001 or.
- IRWrite, RegWrite, MemWrite, PCEn  out  1  write strobes.
- illegal  out  1  one-cycle pulse on undecodable opcode/funct.
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.
- state  out  4  current state encoding (debug).

## Operation
- States (encoding):
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXEC, 7 ALUWB, 8 BRANCH, 9 IEXEC, 10 IMMWB, 11 JUMP.
- Unlisted outputs are 0; ALUControl defaults to 010.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01.
  - IRWrite=PCEn=mem_ready (PCSrc=00).
  - Stays in FETCH while mem_ready=0; advances to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, add. Next state by opcode:
  - 100011/101011 → MEMADR
  - 000000 → EXEC
  - 000100 → BRANCH; 000101 → BRANCH (EXT_OPS)
  - 001000 → IEXEC; 001100/001101/001010 → IEXEC (EXT_OPS)
  - 000010 → JUMP
  - anything else → FETCH with illegal=1.
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. lw → MEMRD; sw → MEMWR.
- MEMRD: IorD=1; holds until mem_ready, then MEMWB.
- MEMWB: MemtoReg=1, RegWrite=1 → FETCH.
- MEMWR: IorD=1, MemWrite=1; held asserted until mem_ready cycle, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00. ALUControl from funct:
  - 100000 → 010; 100010 → 100; 101010 → 110; 011100 → 101
  - 100100 → 000; 100101 → 001 (EXT_OPS only)
  - Unknown funct: illegal=1, ALUControl=010, next FETCH without write. Otherwise → ALUWB.
- ALUWB: RegDst=1, RegWrite=1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=100, PCSrc=01.
  - PCEn = zero (beq) or ~zero (bne) → FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10.
  - addi 010; andi 000 with ZeroExt=1; ori 001 with ZeroExt=1; slti 110.
  - → IMMWB.
- IMMWB: RegWrite=1 → FETCH.
- JUMP: PCSrc=10, PCEn=1 → FETCH.
- instr_count increments by 1 on every transition into FETCH from MEMWB, MEMWR (on mem_ready), ALUWB, BRANCH, IMMWB or JUMP.
  - Illegal paths do not count.
  - Wrap from all-ones to 0.
- Opcode/funct are sampled combinationally; IR must hold them stable from DECODE until the return to FETCH.

## Timing
- Reset (rst_n=0 at a rising edge): state=FETCH, instr_count=0.
  - While rst_n=0, IRWrite, PCEn, RegWrite, MemWrite and illegal are forced 0.
  - Reset mid-instruction aborts it with no further strobes.
- Zero-wait latency (FETCH to next FETCH): lw 5, sw 4, R-type 4, addi/andi/ori/slti 4, beq/bne 3, j 3, illegal 2 cycles.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle; the state and all outputs are held constant.
- MEM_WAIT=0: the wait states never occur.
- Strobes are asserted for exactly one cycle per instruction, except MemWrite, which is held for the whole MEMWR dwell.

## Test plan
- Reset, then rst_n=1, mem_ready=1, lw (100011) → states 0,1,2,3,4,0.
  - IRWrite/PCEn in cycle 0; RegWrite+MemtoReg in state 4; instr_count=1.
- R-type with funct 101010, then 011100 → ALUControl 110 then 101 in EXEC; RegDst=RegWrite=1 in ALUWB; 4 cycles each.
- beq with zero=1 → PCEn=1; bne (EXT_OPS=1) with zero=1 → PCEn=0. Both take 3 cycles and instr_count advances by 2.
- sw with mem_ready low for 3 cycles in MEMWR → MemWrite held 4 cycles, single transition to FETCH.
  - Same stall in FETCH → IRWrite=0 until the ready cycle.
- EXT_OPS=0, opcode 001101 → illegal pulse in DECODE, next FETCH, instr_count unchanged.
  - R-type funct 000000 → illegal in EXEC.
- rst_n=0 asserted in MEMRD → next state FETCH, instr_count=0, no RegWrite.
  - Preload count to 2^CNT_W−1 (CNT_W=4, 15 jumps), then a further j → instr_count wraps to 0.
